pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central in-order pipeline controller. Owns the per-stage valid bits,
//   the IDLE/RUN/DRAIN/DONE sequencing and the stall/bubble/flush decisions
//   (load-use, branch operand dependence, variable-latency data memory).
//   It drives the PC and pipeline-register load enables.
//
//   Build option: define STALL_COUNTER_EN to keep the stall-cycle counter.
//   Without it the counter register is removed and stallCount reads 0.
//   The port list is the same either way.
//
// Ports
//   clk, rstN            clock, synchronous active-low reset
//   startProcess         start request (IDLE/DONE -> RUN)
//   haltID               ID holds the end-of-program marker
//   flushReq             taken jump/branch resolved in ID
//   branchID             ID instruction reads registers for branch/jalr
//   rs1ID/rs2ID          ID source registers
//   rs1UsedID/rs2UsedID  source register actually read
//   rdEX, regWriteEX,    EX destination and control bits
//   memReadEX
//   rdMem, memReadMem    MEM destination and load flag
//   memReqMem,           MEM access request and memory ready
//   memReadyMem
//   stageEn              bit0 = PC write enable, bit i = load enable of the
//                        register feeding stage i (combinational)
//   stageValid           valid bit per stage (registered)
//   bubbleEX             zero control bits entering EX (combinational)
//   running              state is RUN or DRAIN (combinational)
//   endProcess           program finished, high only in DONE (registered)
//   stallCount           cycles with any stall, saturating (registered)
module pipeline_ctrl #(
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned MEM_STAGE  = 3,
   parameter int unsigned REG_SIZE   = 5,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  startProcess,
   input  logic                  haltID,
   input  logic                  flushReq,
   input  logic                  branchID,
   input  logic [REG_SIZE-1:0]   rs1ID,
   input  logic [REG_SIZE-1:0]   rs2ID,
   input  logic                  rs1UsedID,
   input  logic                  rs2UsedID,
   input  logic [REG_SIZE-1:0]   rdEX,
   input  logic                  regWriteEX,
   input  logic                  memReadEX,
   input  logic [REG_SIZE-1:0]   rdMem,
   input  logic                  memReadMem,
   input  logic                  memReqMem,
   input  logic                  memReadyMem,
   output logic [NUM_STAGES-1:0] stageEn,
   output logic [NUM_STAGES-1:0] stageValid,
   output logic                  bubbleEX,
   output logic                  running,
   output logic                  endProcess,
   output logic [CNT_WIDTH-1:0]  stallCount
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                r_state, w_nextState;
   logic [NUM_STAGES-1:0] r_valid, w_nextValid;
   logic                  r_end;

   logic w_depEX, w_depMem;
   logic w_memStall, w_loadUse, w_brHaz, w_idStall, w_stall, w_running;

   // Register x0 never creates a dependence.
   assign w_depEX  = (rdEX != '0) &&
                     ((rs1UsedID && (rs1ID == rdEX)) || (rs2UsedID && (rs2ID == rdEX)));
   assign w_depMem = (rdMem != '0) &&
                     ((rs1UsedID && (rs1ID == rdMem)) || (rs2UsedID && (rs2ID == rdMem)));

   assign w_memStall = r_valid[MEM_STAGE] & memReqMem & ~memReadyMem;
   assign w_loadUse  = r_valid[1] & r_valid[2] & memReadEX & w_depEX;
   assign w_brHaz    = r_valid[1] & branchID &
                       ((regWriteEX & r_valid[2] & w_depEX) |
                        (memReadMem & r_valid[MEM_STAGE] & w_depMem));
   assign w_idStall  = (w_loadUse | w_brHaz) & ~w_memStall;
   assign w_stall    = w_memStall | w_idStall;
   assign w_running  = (r_state == S_RUN) || (r_state == S_DRAIN);

   // Next state and combinational outputs
   always_comb begin
      w_nextState = r_state;
      stageEn     = '0;
      bubbleEX    = 1'b1;
      case (r_state)
         S_IDLE:  if (startProcess) w_nextState = S_RUN;
         S_RUN:   if (r_valid[1] && haltID && !w_stall) w_nextState = S_DRAIN;
         S_DRAIN: if (r_valid == '0) w_nextState = S_DONE;
         S_DONE:  if (startProcess) w_nextState = S_RUN;
         default: w_nextState = S_IDLE;
      endcase
      if (w_running) begin
         bubbleEX = w_idStall;
         for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (w_memStall)     stageEn[i] = (i > MEM_STAGE);
            else if (w_idStall) stageEn[i] = (i > 1);
            else                stageEn[i] = 1'b1;
         end
      end
   end

   // Valid-bit movement: stages at or behind the stalled stage hold, the
   // slot just past it takes a bubble, everything further ahead advances.
   always_comb begin
      w_nextValid = '0;
      if (w_running) begin
         for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            if (w_memStall)
               w_nextValid[i] = (i <= MEM_STAGE) ? r_valid[i] :
                                (i == MEM_STAGE + 1) ? 1'b0 : r_valid[i-1];
            else if (w_idStall)
               w_nextValid[i] = (i <= 1) ? r_valid[i] :
                                (i == 2) ? 1'b0 : r_valid[i-1];
            else
               w_nextValid[i] = r_valid[i-1];
         end
         if (!w_stall && flushReq) w_nextValid[1] = 1'b0;
      end
      w_nextValid[0] = (w_nextState == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_state <= S_IDLE;
         r_valid <= '0;
         r_end   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_valid <= w_nextValid;
         r_end   <= (w_nextState == S_DONE);
      end
   end

`ifdef STALL_COUNTER_EN
   logic [CNT_WIDTH-1:0] r_stallCnt;

   always_ff @(posedge clk) begin
      if (!rstN)
         r_stallCnt <= '0;
      else if (((r_state == S_IDLE) || (r_state == S_DONE)) && (w_nextState == S_RUN))
         r_stallCnt <= '0;
      else if (w_running && w_stall && (r_stallCnt != '1))
         r_stallCnt <= r_stallCnt + 1'b1;
   end

   assign stallCount = r_stallCnt;
`else
   assign stallCount = '0;
`endif

   assign stageValid = r_valid;
   assign running    = w_running;
   assign endProcess = r_end;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
//   Scoreboard bench for pipeline_ctrl. Two instances share one input set:
//   the default 5-stage build and a 7-stage build with MEM at stage 4.
//   A directed prologue walks start, load-use, memory wait, flush vs stall
//   and halt/drain/restart; random traffic follows. A reference model of
//   pipeline occupancy predicts every output of both instances each cycle.
module tb_pipeline_ctrl;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;
   localparam int NCYC    = 3000;

   typedef struct packed {
      logic       rstN, start, halt, flush, br;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rdEX;
      logic       rw, mrEX;
      logic [4:0] rdMem;
      logic       mrMem, req, rdy;
   } in_t;

   typedef struct packed {
      logic [7:0]  en;
      logic [7:0]  vld;
      logic        bub, run, endp;
      logic [15:0] cnt;
   } exp_t;

   typedef struct packed {
      int          st;
      logic [7:0]  occ;
      logic [15:0] cnt;
      logic        endp;
   } mdl_t;

   logic       clk = 1'b0;
   logic       rstN, startProcess, haltID, flushReq, branchID;
   logic [4:0] rs1ID, rs2ID, rdEX, rdMem;
   logic       rs1UsedID, rs2UsedID, regWriteEX, memReadEX;
   logic       memReadMem, memReqMem, memReadyMem;

   logic [4:0]  enA, vldA;
   logic [6:0]  enB, vldB;
   logic        bubA, runA, endA, bubB, runB, endB;
   logic [15:0] cntA, cntB;

   int nchk = 0;
   int nerr = 0;
   exp_t qA[$];
   exp_t qB[$];

   always #5 clk = ~clk;

   pipeline_ctrl dutA (
      .clk(clk), .rstN(rstN), .startProcess(startProcess), .haltID(haltID),
      .flushReq(flushReq), .branchID(branchID), .rs1ID(rs1ID), .rs2ID(rs2ID),
      .rs1UsedID(rs1UsedID), .rs2UsedID(rs2UsedID), .rdEX(rdEX),
      .regWriteEX(regWriteEX), .memReadEX(memReadEX), .rdMem(rdMem),
      .memReadMem(memReadMem), .memReqMem(memReqMem), .memReadyMem(memReadyMem),
      .stageEn(enA), .stageValid(vldA), .bubbleEX(bubA), .running(runA),
      .endProcess(endA), .stallCount(cntA)
   );

   pipeline_ctrl #(.NUM_STAGES(7), .MEM_STAGE(4)) dutB (
      .clk(clk), .rstN(rstN), .startProcess(startProcess), .haltID(haltID),
      .flushReq(flushReq), .branchID(branchID), .rs1ID(rs1ID), .rs2ID(rs2ID),
      .rs1UsedID(rs1UsedID), .rs2UsedID(rs2UsedID), .rdEX(rdEX),
      .regWriteEX(regWriteEX), .memReadEX(memReadEX), .rdMem(rdMem),
      .memReadMem(memReadMem), .memReqMem(memReqMem), .memReadyMem(memReadyMem),
      .stageEn(enB), .stageValid(vldB), .bubbleEX(bubB), .running(runB),
      .endProcess(endB), .stallCount(cntB)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: occupancy of n pipeline slots with the data memory at ms.
   function automatic void step(input mdl_t m, input in_t x, input int n, input int ms,
                                output exp_t e, output mdl_t nm);
      bit run, memSt, dEX, dMem, lu, brh, ids, stall;
      int nst, hold;
      logic [7:0] nocc;
      run   = (m.st == M_RUN) || (m.st == M_DRAIN);
      memSt = m.occ[ms] && x.req && !x.rdy;
      dEX   = (x.rdEX != 0) && ((x.u1 && x.rs1 == x.rdEX) || (x.u2 && x.rs2 == x.rdEX));
      dMem  = (x.rdMem != 0) && ((x.u1 && x.rs1 == x.rdMem) || (x.u2 && x.rs2 == x.rdMem));
      lu    = m.occ[1] && m.occ[2] && x.mrEX && dEX;
      brh   = m.occ[1] && x.br && ((x.rw && m.occ[2] && dEX) || (x.mrMem && m.occ[ms] && dMem));
      ids   = (lu || brh) && !memSt;
      stall = memSt || ids;

      e = '0;
      if (run)
         for (int i = 0; i < n; i++)
            e.en[i] = !((memSt && i <= ms) || (!memSt && ids && i <= 1));
      e.vld  = m.occ;
      e.bub  = !run || ids;
      e.run  = run;
      e.endp = m.endp;
      e.cnt  = m.cnt;

      nm = '0;
      nm.st = M_IDLE;
      if (x.rstN) begin
         nst = m.st;
         if ((m.st == M_IDLE || m.st == M_DONE) && x.start) nst = M_RUN;
         if (m.st == M_RUN && m.occ[1] && x.halt && !stall) nst = M_DRAIN;
         if (m.st == M_DRAIN && m.occ == 0) nst = M_DONE;
         nocc = '0;
         if (run) begin
            hold = memSt ? ms : (ids ? 1 : -1);
            for (int i = 1; i < n; i++) begin
               if (i <= hold)          nocc[i] = m.occ[i];
               else if (i == hold + 1) nocc[i] = 1'b0;
               else                    nocc[i] = m.occ[i-1];
            end
            if (!stall && x.flush) nocc[1] = 1'b0;
         end
         nocc[0] = (nst == M_RUN);
         nm.st   = nst;
         nm.occ  = nocc;
         nm.endp = (nst == M_DONE);
`ifdef STALL_COUNTER_EN
         if ((m.st == M_IDLE || m.st == M_DONE) && nst == M_RUN) nm.cnt = '0;
         else if (run && stall && m.cnt != 16'hFFFF)            nm.cnt = m.cnt + 16'd1;
         else                                                    nm.cnt = m.cnt;
`endif
      end
   endfunction

   function automatic in_t idle_in();
      in_t x;
      x = '0;
      x.rstN = 1'b1;
      x.rdy  = 1'b1;
      return x;
   endfunction

   function automatic in_t dir_in(input int c);
      in_t x;
      x = idle_in();
      case (c)
         0, 1:       x.rstN = 1'b0;
         2, 27:      x.start = 1'b1;
         8, 15: begin
            x.mrEX = 1'b1; x.rdEX = 5'd5; x.rs1 = 5'd5; x.u1 = 1'b1;
            x.flush = (c == 15);
         end
         10: begin
            x.mrEX = 1'b1; x.rdEX = 5'd0; x.rs1 = 5'd0; x.u1 = 1'b1;
         end
         11, 12, 13: begin
            x.req = 1'b1; x.rdy = 1'b0;
         end
         16:         x.flush = 1'b1;
         18:         x.halt = 1'b1;
         default: ;
      endcase
      return x;
   endfunction

   function automatic in_t rnd_in(input int c);
      in_t x;
      x.rstN  = !(($urandom_range(299) == 0) || (c == 1500));
      x.start = ($urandom_range(7) == 0);
      x.halt  = ($urandom_range(29) == 0);
      x.flush = ($urandom_range(5) == 0);
      x.br    = ($urandom_range(3) == 0);
      x.rs1   = 5'($urandom_range(3));
      x.rs2   = 5'($urandom_range(3));
      x.u1    = ($urandom_range(3) != 0);
      x.u2    = ($urandom_range(3) != 0);
      x.rdEX  = 5'($urandom_range(3));
      x.rw    = ($urandom_range(1) == 0);
      x.mrEX  = ($urandom_range(2) == 0);
      x.rdMem = 5'($urandom_range(3));
      x.mrMem = ($urandom_range(2) == 0);
      x.req   = ($urandom_range(1) == 0);
      x.rdy   = ($urandom_range(2) != 0);
      return x;
   endfunction

   task automatic drive(input in_t x);
      rstN = x.rstN; startProcess = x.start; haltID = x.halt; flushReq = x.flush;
      branchID = x.br; rs1ID = x.rs1; rs2ID = x.rs2; rs1UsedID = x.u1; rs2UsedID = x.u2;
      rdEX = x.rdEX; regWriteEX = x.rw; memReadEX = x.mrEX; rdMem = x.rdMem;
      memReadMem = x.mrMem; memReqMem = x.req; memReadyMem = x.rdy;
   endtask

   // Constant expectations for the 5-stage instance during the prologue.
   task automatic directed_checks(input int c);
      logic [15:0] c1, c4;
`ifdef STALL_COUNTER_EN
      c1 = 16'd1; c4 = 16'd4;
`else
      c1 = 16'd0; c4 = 16'd0;
`endif
      case (c)
         3: begin chk("start_valid", 32'(vldA), 32'h01); chk("start_running", 32'(runA), 32'h1); end
         7:  chk("fill_valid", 32'(vldA), 32'h1F);
         8: begin chk("loaduse_en", 32'(enA[1:0]), 32'h0); chk("loaduse_bubble", 32'(bubA), 32'h1); end
         9: begin
            chk("after_lu_en", 32'(enA), 32'h1F); chk("after_lu_bubble", 32'(bubA), 32'h0);
            chk("after_lu_count", 32'(cntA), 32'(c1));
         end
         10: begin chk("rd0_en", 32'(enA), 32'h1F); chk("rd0_bubble", 32'(bubA), 32'h0); end
         11, 12, 13: begin
            chk("memwait_en", 32'(enA[3:0]), 32'h0); chk("memwait_wb", 32'(vldA[4]), 32'h0);
         end
         14: begin chk("memresume_en", 32'(enA), 32'h1F); chk("memwait_count", 32'(cntA), 32'(c4)); end
         15: begin chk("flush_vs_stall_bub", 32'(bubA), 32'h1); chk("flush_vs_stall_en", 32'(enA[1:0]), 32'h0); end
         17: chk("flush_kill", 32'(vldA[1]), 32'h0);
         19: begin chk("drain_fetch_off", 32'(vldA[0]), 32'h0); chk("drain_running", 32'(runA), 32'h1); end
         26: begin chk("done_end", 32'(endA), 32'h1); chk("done_running", 32'(runA), 32'h0); end
         28: begin
            chk("restart_running", 32'(runA), 32'h1); chk("restart_count", 32'(cntA), 32'h0);
            chk("restart_end", 32'(endA), 32'h0);
         end
         default: ;
      endcase
   endtask

   // Monitor: compare whatever the scoreboard expects for this cycle.
   always @(negedge clk) begin
      exp_t e;
      if (qA.size() > 0) begin
         e = qA.pop_front();
         chk("A.stageEn", 32'(enA), 32'(e.en[4:0]));
         chk("A.stageValid", 32'(vldA), 32'(e.vld[4:0]));
         chk("A.bubbleEX", 32'(bubA), 32'(e.bub));
         chk("A.running", 32'(runA), 32'(e.run));
         chk("A.endProcess", 32'(endA), 32'(e.endp));
         chk("A.stallCount", 32'(cntA), 32'(e.cnt));
      end
      if (qB.size() > 0) begin
         e = qB.pop_front();
         chk("B.stageEn", 32'(enB), 32'(e.en[6:0]));
         chk("B.stageValid", 32'(vldB), 32'(e.vld[6:0]));
         chk("B.bubbleEX", 32'(bubB), 32'(e.bub));
         chk("B.running", 32'(runB), 32'(e.run));
         chk("B.endProcess", 32'(endB), 32'(e.endp));
         chk("B.stallCount", 32'(cntB), 32'(e.cnt));
      end
   end

   initial begin
      in_t  x;
      mdl_t mA, mB, nA, nB;
      exp_t eA, eB;
      mA = '0;
      mB = '0;
      for (int c = 0; c < NCYC; c++) begin
         x = (c < 30) ? dir_in(c) : rnd_in(c);
         drive(x);
         step(mA, x, 5, 3, eA, nA);
         step(mB, x, 7, 4, eB, nB);
         // Cycle 0 precedes the first reset edge, so outputs are unknown.
         if (c > 0) begin
            qA.push_back(eA);
            qB.push_back(eB);
         end
         mA = nA;
         mB = nB;
         if (c < 30) begin
            #3;
            directed_checks(c);
         end
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < 10 && (qA.size() != 0 || qB.size() != 0); k++) @(negedge clk);
      if (qA.size() != 0 || qB.size() != 0) begin
         nchk++;
         nerr++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", qA.size() + qB.size());
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
